fifo_rd_ctrl: RTL
=================

# fifo_rd_ctrl

Read-side controller of the asynchronous FIFO, directly downstream of the write-side gray pointer counter. It takes the writer's gray-coded pointer from the foreign clock domain and synchronises it into its own clock. It owns the read pointer and produces the RAM read address, the empty flag, an underflow pulse and, optionally, the fill level.

## Interface
- ADDR_WIDTH, 4, RAM address width; FIFO depth is 2^ADDR_WIDTH
- SYNC_STAGES, 2, synchroniser flops on the incoming write pointer (minimum 2)
- clk_i  input  1  read-domain clock; all logic on posedge
- rst_i  input  1  reset; synchronous and active-high
- wrPtrGray_i  input  ADDR_WIDTH+1  writer's gray pointer from the foreign domain; changes at most one bit at a time
- rd_en_i  input  1  consume one entry this cycle
- empty_o  output  1  registered; FIFO empty as seen from the read domain
- rdAddr_o  output  ADDR_WIDTH  binary RAM read address (low bits of the read pointer)
- rdPtrGray_o  output  ADDR_WIDTH+1  gray read pointer, registered, for the writer's full-flag synchroniser
- level_o  output  ADDR_WIDTH+1  registered occupancy, 0..2^ADDR_WIDTH
- underflow_o  output  1  one-cycle pulse: read requested while empty

## Operation
- PTR_W = ADDR_WIDTH+1; the extra MSB distinguishes a full FIFO from an empty one.
- Synchroniser: wrPtrGray_i passes through SYNC_STAGES flops, all reset to 0; wrSync is the value entering the last stage this edge.
- Read pointer: gray_counter, WIDTH=PTR_W, en = rd_en_i & ~empty_o.
  - rdNew = nextCount when advancing, else count.
- Empty: empty_o <= (rdNew == wrSync), compared in gray; no binary conversion on the flag path.
- Underflow: underflow_o <= rd_en_i & empty_o; the pointer does not move and there is no error state.
- rdAddr_o = gray-to-binary(rdPtrGray_o)[ADDR_WIDTH-1:0].
- Level: level_o <= (bin(wrSync) - bin(rdNew)) mod 2^PTR_W; the result never exceeds 2^ADDR_WIDTH for a legal writer.
- Wrap-around: pointers wrap naturally at 2^PTR_W; no special casing.
- Reset values: empty_o=1, rdPtrGray_o=0, rdAddr_o=0, level_o=0, underflow_o=0, all synchroniser stages 0.
- Reset mid-operation discards the contents from this side; the writer must be reset with it.

## Timing
- A write pointer change before edge n is reflected in empty_o and level_o after edge n+SYNC_STAGES-1.
- A read (rd_en_i=1, empty_o=0) at edge n:
  - rdPtrGray_o and rdAddr_o advance at edge n.
  - empty_o and level_o reflect the read at edge n.
  - Data for the old rdAddr_o is valid in the RAM at edge n; the RAM read is combinational or registered by the RAM owner.
- Simultaneous read and incoming write are handled in the same edge, since both feed rdNew and wrSync.
- Back-to-back reads every cycle until empty are legal; the read that empties the FIFO sets empty_o at that same edge.
- rst_i dominates rd_en_i.

## Configuration
- FIFO_RD_LEVEL_EN defined:
  - both gray decoders are present and level_o is computed as above.
- FIFO_RD_LEVEL_EN undefined:
  - level_o is tied to 0 and the wrSync decoder is removed.
  - empty_o, underflow_o and the pointers are unchanged.

## Structure
- Package fifo_pkg holds:
  - the PTR_W derivation,
  - the pointer reset constant,
  - the minimum SYNC_STAGES constant, shared with the future fifo_wr_ctrl.
- Sub-module gray_decoder (parameter WIDTH): combinational gray-to-binary. It is instanced for the read pointer and, when the level feature is enabled, for wrSync.
- Reuse gray_counter for the read pointer; no new counter.

## Test plan
ADDR_WIDTH=2, SYNC_STAGES=2 unless noted.
- Reset: hold rst_i 2 cycles -> empty_o=1, rdPtrGray_o=000, rdAddr_o=0, level_o=0, underflow_o=0.
- Sync latency: wrPtrGray_i 000->001 before edge 0 -> empty_o falls and level_o=1 after edge 1, not before.
- Full drain: wrPtrGray_i=110 (bin 4) settled, level_o=4; hold rd_en_i 5 cycles:
  - rdAddr_o steps 0,1,2,3; empty_o=1 after the 4th edge with level_o=0.
  - 5th cycle gives underflow_o=1 for one cycle, rdPtrGray_o stays 110.
- Wrap: read pointer at 100 (bin 7), wrPtrGray_i=000 (bin 8 mod 8) -> level_o=1; one read -> rdPtrGray_o=000, rdAddr_o=0, empty_o=1.
- Reset mid-run: level_o=3 with wrPtrGray_i=011; pulse rst_i -> reset values next edge, then level_o=2 and empty_o=0 two cycles after release.
- Build without FIFO_RD_LEVEL_EN, repeat the full-drain case -> identical empty_o, rdAddr_o and underflow_o; level_o constant 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: pointer width derivation, pointer reset value and
// the synchroniser depth floor used by both FIFO controllers.
package fifo_pkg;

    localparam int SYNC_STAGES_MIN = 2;

    localparam logic [31:0] PTR_RST = '0;

    function automatic int ptr_w(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/gray_counter.sv
// Registered gray-code counter with an enable; nextCount is the code the
// counter would hold after one advance.
module gray_counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] nextCount
);

    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] binNext;

    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(count >> i);
        end
        binNext   = bin + {{(WIDTH-1){1'b0}}, 1'b1};
        nextCount = binNext ^ (binNext >> 1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (en) begin
            count <= nextCount;
        end
    end

endmodule

// File: rtl/gray_decoder.sv
// Combinational gray-to-binary conversion of a WIDTH-bit code.
module gray_decoder #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Binary bit i is the parity of all gray bits at and above i.
    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: write-pointer synchroniser, gray read
// pointer, empty/underflow flags. Fill level is built only with FIFO_RD_LEVEL_EN.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH:0]   wrPtrGray_i,
    input  logic                  rd_en_i,
    output logic                  empty_o,
    output logic [ADDR_WIDTH-1:0] rdAddr_o,
    output logic [ADDR_WIDTH:0]   rdPtrGray_o,
    output logic [ADDR_WIDTH:0]   level_o,
    output logic                  underflow_o
);

    localparam int PTR_W = ptr_w(ADDR_WIDTH);

    if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync
        $error("fifo_rd_ctrl: SYNC_STAGES below minimum");
    end

    // Synchroniser front stages; the empty/level registers act as the final
    // stage, so wrSync is the value entering that stage this edge.
    logic [PTR_W-1:0] wrSync_p [SYNC_STAGES-1];
    logic [PTR_W-1:0] wrSync;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES - 1; i++) begin
                wrSync_p[i] <= PTR_RST[PTR_W-1:0];
            end
        end else begin
            wrSync_p[0] <= wrPtrGray_i;
            for (int i = 1; i < SYNC_STAGES - 1; i++) begin
                wrSync_p[i] <= wrSync_p[i-1];
            end
        end
    end

    assign wrSync = wrSync_p[SYNC_STAGES-2];

    // Read pointer
    logic             advance;
    logic [PTR_W-1:0] rdNextGray;
    logic [PTR_W-1:0] rdNew;
    logic [PTR_W-1:0] rdBin;

    assign advance = rd_en_i & ~empty_o;

    gray_counter #(
        .WIDTH(PTR_W)
    ) u_rd_ptr (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en       (advance),
        .count    (rdPtrGray_o),
        .nextCount(rdNextGray)
    );

    assign rdNew = advance ? rdNextGray : rdPtrGray_o;

    gray_decoder #(
        .WIDTH(PTR_W)
    ) u_rd_dec (
        .gray(rdPtrGray_o),
        .bin (rdBin)
    );

    assign rdAddr_o = rdBin[ADDR_WIDTH-1:0];

    // Flags: empty compares gray codes directly, keeping decoders off this path.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            empty_o     <= 1'b1;
            underflow_o <= 1'b0;
        end else begin
            empty_o     <= (rdNew == wrSync);
            underflow_o <= rd_en_i & empty_o;
        end
    end

`ifdef FIFO_RD_LEVEL_EN
    logic [PTR_W-1:0] wrBin;
    logic [PTR_W-1:0] rdNewBin;
    logic [PTR_W-1:0] levelQ;

    gray_decoder #(
        .WIDTH(PTR_W)
    ) u_wr_dec (
        .gray(wrSync),
        .bin (wrBin)
    );

    // The post-read binary pointer is the current one plus the advance bit.
    assign rdNewBin = rdBin + {{(PTR_W-1){1'b0}}, advance};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            levelQ <= '0;
        end else begin
            levelQ <= wrBin - rdNewBin;
        end
    end

    assign level_o = levelQ;
`else
    logic unused_rdMsb;

    assign unused_rdMsb = rdBin[PTR_W-1];
    assign level_o      = '0;
`endif

endmodule
